// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs, scan FSM states
// and default timing parameters used by the decoder and the display driver.
package seg7_pkg;

   localparam int SETTLE_CYCLES_DEF  = 4;
   localparam int TIMEOUT_CYCLES_DEF = 65536;

   // Active-low patterns, bit0 = segment a ... bit6 = segment g
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   localparam logic [15:0][6:0] GLYPH_TBL = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } scan_state_e;

   function automatic logic an_legal(input logic [3:0] an);
      return ($countones(~an) == 1);
   endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble,
// with a flag that is low for any pattern that is not one of the 16 glyphs.
module seg7_to_nibble
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] nibble_o,
   output logic       legal_o
);

   always_comb begin
      nibble_o = 4'h0;
      legal_o  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern_i == GLYPH_TBL[i]) begin
            nibble_o = 4'(i);
            legal_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value by snooping a multiplexed 7-segment display
// bus: each digit is captured once its anode/segment pair has settled.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  AN,
   input  logic [6:0]  seven,
   output logic [15:0] value,
   output logic        valid,
   output logic        frame_stb,
   output logic        seg_err
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]      an_s1_q, an_s2_q, an_prev_q;
   logic [6:0]      sev_s1_q, sev_s2_q, sev_prev_q;
   scan_state_e     state_q, state_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [3:0][3:0] slot_q, slot_d;
   logic [3:0]      seen_q, seen_d;
   logic [15:0]     value_q, value_d;
   logic            valid_q, valid_d, stb_q, stb_d, err_q, err_d;
   logic [3:0]      nib;
   logic            glyph_ok, changed, an_ok, capture, good_cap, complete;
   logic [1:0]      sel;

   seg7_to_nibble u_dec (
      .pattern_i (sev_s2_q),
      .nibble_o  (nib),
      .legal_o   (glyph_ok)
   );

   // The third stage keeps the previous synchronized sample for change detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         an_s1_q    <= '1;
         an_s2_q    <= '1;
         an_prev_q  <= '1;
         sev_s1_q   <= '1;
         sev_s2_q   <= '1;
         sev_prev_q <= '1;
      end else begin
         an_s1_q    <= AN;
         an_s2_q    <= an_s1_q;
         an_prev_q  <= an_s2_q;
         sev_s1_q   <= seven;
         sev_s2_q   <= sev_s1_q;
         sev_prev_q <= sev_s2_q;
      end
   end

   assign changed  = (an_s2_q != an_prev_q) || (sev_s2_q != sev_prev_q);
   assign an_ok    = an_legal(an_s2_q);
   assign good_cap = capture && glyph_ok;
   assign complete = (seen_q == 4'hF);

   always_comb begin
      sel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!an_s2_q[i]) sel = 2'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         ST_WAIT: begin
            if (an_ok) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (changed) begin
               cnt_d = '0;
               if (!an_ok) state_d = ST_WAIT;
            end else if (cnt_q == SETTLE_LAST) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         ST_HOLD: begin
            if (changed) begin
               cnt_d   = '0;
               state_d = an_ok ? ST_SETTLE : ST_WAIT;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   // Frame completion takes priority over a coincident timeout
   always_comb begin
      slot_d  = slot_q;
      seen_d  = seen_q;
      value_d = value_q;
      valid_d = valid_q;
      tmo_d   = tmo_q;
      stb_d   = 1'b0;
      err_d   = capture && !glyph_ok;
      if (complete) begin
         value_d = slot_q;
         stb_d   = 1'b1;
         valid_d = 1'b1;
         seen_d  = '0;
         tmo_d   = '0;
      end else if (good_cap) begin
         slot_d[sel] = nib;
         seen_d[sel] = 1'b1;
         tmo_d       = '0;
      end else if (tmo_q == TMO_LAST) begin
         tmo_d   = TMO_MAX;
         valid_d = 1'b0;
         seen_d  = '0;
      end else if (tmo_q != TMO_MAX) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         cnt_q   <= '0;
         tmo_q   <= '0;
         slot_q  <= '0;
         seen_q  <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         slot_q  <= slot_d;
         seen_q  <= seen_d;
         value_q <= value_d;
         valid_q <= valid_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
      end
   end

   assign value     = value_q;
   assign valid     = valid_q;
   assign frame_stb = stb_q;
   assign seg_err   = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random bus traffic, checked
// every cycle against a run-length based behavioural model.
module tb_seg7_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TMO    = 200;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  AN    = 4'hF;
   logic [6:0]  seven = 7'h7F;
   logic [15:0] value;
   logic        valid, frame_stb, seg_err;

   seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock     (clock),
      .reset     (reset),
      .AN        (AN),
      .seven     (seven),
      .value     (value),
      .valid     (valid),
      .frame_stb (frame_stb),
      .seg_err   (seg_err)
   );

   always #5 clock = ~clock;

   // Conventional active-high gfedcba encodings; the bus carries their inverse
   logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int checks = 0;
   int errors = 0;
   int n_stb  = 0;
   int n_err  = 0;

   logic [10:0] past1, past2, last_x;
   int          run;
   logic [3:0]  m_slot [4];
   logic [3:0]  m_seen;
   logic [15:0] m_value;
   logic        m_valid, m_stb, m_err;
   int          m_tmo;

   function automatic logic [6:0] glyph(input int n);
      return ~seg_hi[n];
   endfunction

   function automatic int glyph_of(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (p == ~seg_hi[i]) return i;
      return -1;
   endfunction

   function automatic int digit_of(input logic [3:0] an);
      case (an)
         4'hE:    return 0;
         4'hD:    return 1;
         4'hB:    return 2;
         4'h7:    return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the synchronized pair seen at an edge is the bus value two edges
   // earlier; a digit is taken when that pair has been identical SETTLE+1 edges.
   initial begin : model
      logic [10:0] x;
      int g, d;
      bit cap, comp;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            past1 = '1; past2 = '1; last_x = '1; run = 1;
            m_value = '0; m_valid = 1'b0; m_stb = 1'b0; m_err = 1'b0;
            m_seen = '0; m_tmo = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
         end else begin
            x = past2; past2 = past1; past1 = {AN, seven};
            if (x == last_x) begin
               if (run < 1000) run++;
            end else begin
               run = 1;
            end
            last_x = x;
            d    = digit_of(x[10:7]);
            g    = glyph_of(x[6:0]);
            cap  = (d >= 0) && (run == SETTLE + 1);
            comp = (m_seen == 4'hF);
            m_stb = 1'b0;
            m_err = cap && (g < 0);
            if (comp) begin
               m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
               m_stb = 1'b1; m_valid = 1'b1; m_seen = '0; m_tmo = 0;
            end else if (cap && g >= 0) begin
               m_slot[d] = g[3:0]; m_seen[d] = 1'b1; m_tmo = 0;
            end else if (m_tmo < TMO) begin
               m_tmo++;
               if (m_tmo == TMO) begin
                  m_valid = 1'b0; m_seen = '0;
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clock);
         chk("value",     value,            m_value);
         chk("valid",     16'(valid),       16'(m_valid));
         chk("frame_stb", 16'(frame_stb),   16'(m_stb));
         chk("seg_err",   16'(seg_err),     16'(m_err));
         n_stb += int'(frame_stb);
         n_err += int'(seg_err);
      end
   end

   task automatic drive(input logic [3:0] an, input logic [6:0] sv, input int cyc);
      AN = an; seven = sv;
      repeat (cyc) @(negedge clock);
   endtask

   task automatic drive_digit(input int pos, input int nib, input int cyc);
      logic [3:0] a;
      a = 4'hF; a[pos] = 1'b0;
      drive(a, glyph(nib), cyc);
   endtask

   task automatic scan(input logic [15:0] v);
      for (int i = 0; i < 4; i++) drive_digit(i, int'(v[4*i +: 4]), 20);
      drive(4'hF, 7'h7F, 10);
   endtask

   task automatic do_reset();
      @(negedge clock); #2 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_value", value, 16'h0000);
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_stb",   16'(frame_stb), 16'h0);
      chk("rst_err",   16'(seg_err), 16'h0);
      #2 reset = 1'b0;
   endtask

   initial begin : stim
      int s0, e0, hold, kind;
      logic [3:0] a;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;

      // Basic scan of 1230
      s0 = n_stb;
      scan(16'h1230);
      chk("s1230_value", value, 16'h1230);
      chk("s1230_model", m_value, 16'h1230);
      chk("s1230_stb",   16'(n_stb - s0), 16'd1);
      chk("s1230_valid", 16'(valid), 16'h1);

      // Too-short hold on digit 0 means the frame can never complete
      do_reset();
      s0 = n_stb;
      drive_digit(0, 5, SETTLE - 1);
      drive(4'hF, 7'h7F, 20);
      for (int i = 1; i < 4; i++) drive_digit(i, 7, 20);
      drive(4'hF, 7'h7F, 10);
      chk("short_stb",   16'(n_stb - s0), 16'd0);
      chk("short_value", value, 16'h0000);

      // Blank glyph on a legal anode
      do_reset();
      s0 = n_stb; e0 = n_err;
      drive(4'hE, 7'h7F, 20);
      chk("blank_err", 16'(n_err - e0), 16'd1);
      for (int i = 1; i < 4; i++) drive_digit(i, 9, 20);
      drive(4'hF, 7'h7F, 10);
      chk("blank_stb", 16'(n_stb - s0), 16'd0);

      // Two anodes low at once is ignored, then BEEF
      do_reset();
      s0 = n_stb; e0 = n_err;
      drive(4'hC, glyph(3), 50);
      chk("multi_err", 16'(n_err - e0), 16'd0);
      chk("multi_stb", 16'(n_stb - s0), 16'd0);
      scan(16'hBEEF);
      chk("beef_value", value, 16'hBEEF);
      chk("beef_valid", 16'(valid), 16'h1);

      // Idle bus until timeout: valid drops, value held
      drive(4'hF, 7'h7F, TMO + 10);
      chk("tmo_valid", 16'(valid), 16'h0);
      chk("tmo_value", value, 16'hBEEF);

      // Reset mid-frame discards partial digits
      for (int i = 0; i < 3; i++) drive_digit(i, i + 1, 20);
      do_reset();
      s0 = n_stb;
      for (int i = 1; i < 4; i++) drive_digit(i, (i == 1) ? 15 : 0, 20);
      drive(4'hF, 7'h7F, 10);
      chk("rst_partial_stb", 16'(n_stb - s0), 16'd0);
      drive_digit(0, 0, 20);
      drive(4'hF, 7'h7F, 10);
      chk("f0_value", value, 16'h00F0);
      chk("f0_stb",   16'(n_stb - s0), 16'd1);

      // Random bus traffic
      do_reset();
      for (int k = 0; k < 400; k++) begin
         kind = $urandom_range(0, 9);
         hold = ($urandom_range(0, 49) == 0) ? TMO + 20 : $urandom_range(1, 12);
         if (kind == 0) begin
            drive(4'($urandom), 7'($urandom), hold);
         end else begin
            a = 4'hF; a[$urandom_range(0, 3)] = 1'b0;
            drive(a, (kind == 1) ? 7'($urandom) : glyph($urandom_range(0, 15)), hold);
         end
      end
      drive(4'hF, 7'h7F, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
